execute_stage_md: RTL and testbench
===================================

# execute_stage_md

Parametrised execute stage for the pipelined MIPS core. It combines operand forwarding, the ALU and a multi-cycle multiply/divide unit with HI/LO registers. It also contains the EX/MEM pipeline register. It sits between the ID/EX register and the memory stage, and it reports `md_busy` to the hazard unit so the hazard unit can stall mult/div/mfhi/mflo/mthi/mtlo in decode.

## Interface
Parameters:
- `DW`, 32: datapath width; must be even and at least 8.
- `MUL_CYCLES`, 5: busy cycles for mult/multu; must be at least 1.
- `DIV_CYCLES`, 10: busy cycles for div/divu; must be at least 1.

Ports:
- `clk`  in  1  clock; every register updates on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `ex_valid`  in  1  the instruction in EX is real; 0 marks a bubble.
- `pc_in`  in  32  PC of the EX instruction.
- `instr_in`  in  32  instruction word.
- `a_in`, `b_in`  in  DW  rs and rt values from the register file.
- `imm_in`  in  DW  extended immediate.
- `wa_in`  in  5  destination register; 0 means no write.
- `fwd_rs`, `fwd_rt`  in  2  forward select: 0 = register-file value, 1 = `fwd_mem`, 2 = `fwd_wb`, 3 = register-file value.
- `fwd_mem`, `fwd_wb`  in  DW  forwarded results from MEM and WB.
- `alu_op`  in  4  ALU function.
- `alu_src`  in  1  1 selects `imm_in` as operand B.
- `md_op`  in  3  multiply/divide operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
- `md_read`  in  2  result source: 0 ALU, 1 HI, 2 LO.
- `md_busy`  out  1  combinational; high while the unit is busy or a mult/div is being issued.
- `pc_out`, `instr_out`  out  32  registered copies of `pc_in` and `instr_in`.
- `result_out`  out  DW  registered result.
- `store_out`  out  DW  registered forwarded rt value (store data).
- `wa_out`  out  5  registered destination register.
- `valid_out`  out  1  registered `ex_valid`.

## Operation
- Operand A = rs value selected by `fwd_rs`. Forwarded rt = rt value selected by `fwd_rt`. Operand B = `alu_src` ? `imm_in` : forwarded rt.
- ALU functions, `alu_op`:
  - 0 add, 1 sub (both wrap, no overflow trap)
  - 2 and, 3 or, 4 xor, 5 nor
  - 6 slt (signed), 7 sltu; result is 0 or 1, zero-extended
  - 8 sll B by A[4:0], 9 srl, 10 sra
  - 11 lui: B shifted left by DW/2
  - any other value gives 0.
- `result_out` next value = `md_read` 1 ? HI : `md_read` 2 ? LO : ALU result. HI/LO are read as they stand in the current cycle.
- `start` = `ex_valid` & `md_op` in {1..4} & !busy.
- On `start`:
  - Capture operand A and forwarded rt.
  - Load the counter with `MUL_CYCLES` or `DIV_CYCLES`; set busy.
- While busy, the counter decrements each cycle. On the edge where the counter is 1, write HI/LO and clear busy.
- mult/multu: form the full 2·DW product, signed or unsigned. HI = upper DW bits, LO = lower DW bits.
- div/divu: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divisor 0: HI and LO stay unchanged, but the busy period still runs its full length.
- Signed overflow (most-negative value / -1): LO = most-negative value, HI = 0.
- mthi/mtlo with `ex_valid`: write operand A to HI or LO at the next edge. This is ignored while busy; the hazard unit prevents that case.
- A mult/div issued while busy is ignored (no restart); the hazard unit prevents that case.
- `md_busy` = busy | `start`.
- EX/MEM register:
  - Loads every cycle.
  - When `ex_valid` = 0, it loads a bubble: all outputs 0, including `valid_out`.
  - A bubble never disturbs an operation already in progress in the multiply/divide unit.

## Timing
- Reset: all outputs 0; HI = LO = 0; busy = 0; counter = 0. Reset mid-operation aborts the operation and leaves HI/LO at 0.
- ALU path: combinational from EX inputs to the EX/MEM register. `result_out` is valid 1 cycle after the instruction occupies EX.
- mult/div issued in EX during cycle t:
  - `md_busy` is high in cycles t through t+N, where N = `MUL_CYCLES` or `DIV_CYCLES`.
  - HI/LO take the new value at the end of cycle t+N.
  - An mfhi/mflo in EX during cycle t+N+1 reads the new value.
- Operands are captured at issue. Later changes to the forwarding inputs do not affect the result.
- An mfhi/mflo in EX on the same cycle as an mthi/mtlo edge reads the old value. The pipeline order makes this case unreachable.

## Test plan
- Reset held 2 cycles during a mult at cycle 3 of 5 → all outputs 0, `md_busy` 0, mfhi returns 0.
- `alu_op` 0 with a = 0x7FFFFFFF, b = 1 → `result_out` 0x80000000 one cycle later. `alu_op` 6 with a = 0xFFFFFFFF, b = 1 → 1. `alu_op` 7 with the same operands → 0.
- `fwd_rs` 1, `fwd_mem` = 0x10, `a_in` = 0x99, add with imm 4 → 0x14. With `fwd_rs` 2 and `fwd_wb` = 0x20 → 0x24.
- mult a = 0xFFFFFFFE (-2), b = 3 → `md_busy` high 6 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA. multu with the same operands → HI = 2, LO = 0xFFFFFFFA.
- div a = -7, b = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF after 11 busy cycles. A following div by 0 → HI and LO unchanged, busy still 11 cycles.
- mtlo a = 0x1234, then mflo → `result_out` 0x1234. A bubble (`ex_valid` 0) during busy → `valid_out` 0 and the operation completes normally.

Source files
------------

// File: rtl/execute_stage_md.sv
// execute_stage_md: operand forwarding, ALU, multi-cycle mult/div unit with HI/LO, EX/MEM register.
// Latency: ALU and HI/LO reads land in result_out 1 cycle later; mult/div update HI/LO N cycles after issue.
// Backpressure: none accepted here; o_md_busy tells the hazard unit to hold mult/div/HI/LO ops in decode.
module execute_stage_md #(
  parameter int DW         = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ex_valid,
  input  logic [31:0]   i_pc_in,
  input  logic [31:0]   i_instr_in,
  input  logic [DW-1:0] i_a_in,
  input  logic [DW-1:0] i_b_in,
  input  logic [DW-1:0] i_imm_in,
  input  logic [4:0]    i_wa_in,
  input  logic [1:0]    i_fwd_rs,
  input  logic [1:0]    i_fwd_rt,
  input  logic [DW-1:0] i_fwd_mem,
  input  logic [DW-1:0] i_fwd_wb,
  input  logic [3:0]    i_alu_op,
  input  logic          i_alu_src,
  input  logic [2:0]    i_md_op,
  input  logic [1:0]    i_md_read,
  output logic          o_md_busy,
  output logic [31:0]   o_pc_out,
  output logic [31:0]   o_instr_out,
  output logic [DW-1:0] o_result_out,
  output logic [DW-1:0] o_store_out,
  output logic [4:0]    o_wa_out,
  output logic          o_valid_out
);

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  // Forwarding and operand selection
  logic [DW-1:0] w_op_a;
  logic [DW-1:0] w_rt;
  logic [DW-1:0] w_op_b;

  // Operand muxes: select 0 and 3 both fall back to the register file value
  always_comb begin
    w_op_a = i_a_in;
    w_rt   = i_b_in;
    if (i_fwd_rs == 2'd1)      w_op_a = i_fwd_mem;
    else if (i_fwd_rs == 2'd2) w_op_a = i_fwd_wb;
    if (i_fwd_rt == 2'd1)      w_rt = i_fwd_mem;
    else if (i_fwd_rt == 2'd2) w_rt = i_fwd_wb;
    w_op_b = i_alu_src ? i_imm_in : w_rt;
  end

  // ALU
  logic [DW-1:0] w_alu;
  logic          w_slt;
  logic          w_sltu;

  assign w_slt  = $signed(w_op_a) < $signed(w_op_b);
  assign w_sltu = w_op_a < w_op_b;

  // ALU function decode; undefined opcodes produce zero
  always_comb begin
    w_alu = '0;
    case (i_alu_op)
      4'd0:    w_alu = w_op_a + w_op_b;
      4'd1:    w_alu = w_op_a - w_op_b;
      4'd2:    w_alu = w_op_a & w_op_b;
      4'd3:    w_alu = w_op_a | w_op_b;
      4'd4:    w_alu = w_op_a ^ w_op_b;
      4'd5:    w_alu = ~(w_op_a | w_op_b);
      4'd6:    w_alu = {{(DW-1){1'b0}}, w_slt};
      4'd7:    w_alu = {{(DW-1){1'b0}}, w_sltu};
      4'd8:    w_alu = w_op_b << w_op_a[4:0];
      4'd9:    w_alu = w_op_b >> w_op_a[4:0];
      4'd10:   w_alu = $signed(w_op_b) >>> w_op_a[4:0];
      4'd11:   w_alu = w_op_b << (DW / 2);
      default: w_alu = '0;
    endcase
  end

  // Multiply/divide unit state
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_hi;
  logic [DW-1:0] r_lo;
  logic [DW-1:0] r_md_a;
  logic [DW-1:0] r_md_b;
  logic          r_is_div;
  logic          r_signed;

  logic w_is_mdop;
  logic w_start;

  assign w_is_mdop = (i_md_op == MD_MULT) || (i_md_op == MD_MULTU) ||
                     (i_md_op == MD_DIV)  || (i_md_op == MD_DIVU);
  assign w_start   = i_ex_valid && w_is_mdop && !r_busy;
  assign o_md_busy = r_busy | w_start;

  // Full-width product: operands are extended to 2*DW so one unsigned multiplier serves both forms
  logic [2*DW-1:0] w_a_ext;
  logic [2*DW-1:0] w_b_ext;
  logic [2*DW-1:0] w_prod;

  assign w_a_ext = r_signed ? {{DW{r_md_a[DW-1]}}, r_md_a} : {{DW{1'b0}}, r_md_a};
  assign w_b_ext = r_signed ? {{DW{r_md_b[DW-1]}}, r_md_b} : {{DW{1'b0}}, r_md_b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Division on magnitudes, signs restored afterwards (quotient truncates toward zero,
  // remainder follows the dividend). Most-negative / -1 falls out as LO = most-negative, HI = 0.
  logic          w_a_neg;
  logic          w_b_neg;
  logic [DW-1:0] w_a_mag;
  logic [DW-1:0] w_b_mag;
  logic [DW-1:0] w_q_mag;
  logic [DW-1:0] w_r_mag;
  logic [DW-1:0] w_q;
  logic [DW-1:0] w_r;
  logic          w_div_zero;

  assign w_a_neg    = r_signed & r_md_a[DW-1];
  assign w_b_neg    = r_signed & r_md_b[DW-1];
  assign w_a_mag    = w_a_neg ? -r_md_a : r_md_a;
  assign w_b_mag    = w_b_neg ? -r_md_b : r_md_b;
  assign w_div_zero = (r_md_b == '0);
  assign w_q_mag    = w_div_zero ? '0 : (w_a_mag / w_b_mag);
  assign w_r_mag    = w_div_zero ? '0 : (w_a_mag % w_b_mag);
  assign w_q        = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_r        = w_a_neg ? -w_r_mag : w_r_mag;

  // Issue, count down, and retire into HI/LO; mthi/mtlo only act when the unit is idle
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_md_a   <= '0;
      r_md_b   <= '0;
      r_is_div <= 1'b0;
      r_signed <= 1'b0;
    end else if (w_start) begin
      r_busy   <= 1'b1;
      r_md_a   <= w_op_a;
      r_md_b   <= w_rt;
      r_is_div <= (i_md_op == MD_DIV) || (i_md_op == MD_DIVU);
      r_signed <= (i_md_op == MD_MULT) || (i_md_op == MD_DIV);
      if ((i_md_op == MD_DIV) || (i_md_op == MD_DIVU)) r_cnt <= CW'(DIV_CYCLES);
      else                                             r_cnt <= CW'(MUL_CYCLES);
    end else if (r_busy) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        if (!r_is_div) begin
          r_hi <= w_prod[2*DW-1:DW];
          r_lo <= w_prod[DW-1:0];
        end else if (!w_div_zero) begin
          r_hi <= w_r;
          r_lo <= w_q;
        end
      end
    end else if (i_ex_valid && (i_md_op == MD_MTHI)) begin
      r_hi <= w_op_a;
    end else if (i_ex_valid && (i_md_op == MD_MTLO)) begin
      r_lo <= w_op_a;
    end
  end

  // Result source: HI/LO as they stand this cycle, otherwise the ALU
  logic [DW-1:0] w_result;

  always_comb begin
    w_result = w_alu;
    if (i_md_read == 2'd1)      w_result = r_hi;
    else if (i_md_read == 2'd2) w_result = r_lo;
  end

  // EX/MEM register: loads every cycle, a bubble clears every field
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_ex_valid) begin
      o_pc_out     <= '0;
      o_instr_out  <= '0;
      o_result_out <= '0;
      o_store_out  <= '0;
      o_wa_out     <= '0;
      o_valid_out  <= 1'b0;
    end else begin
      o_pc_out     <= i_pc_in;
      o_instr_out  <= i_instr_in;
      o_result_out <= w_result;
      o_store_out  <= w_rt;
      o_wa_out     <= i_wa_in;
      o_valid_out  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_execute_stage_md.sv
// tb_execute_stage_md: randomized and directed stimulus against a behavioural model of the execute stage.
// Latency: checks result_out one cycle after issue and HI/LO after the mult/div busy window.
// Backpressure: the bench honours md_busy by only issuing new mult/div once it is low.
module tb_execute_stage_md;
  localparam int DW = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid;
  logic [31:0]   pc_in, instr_in;
  logic [DW-1:0] a_in, b_in, imm_in, fwd_mem, fwd_wb;
  logic [4:0]    wa_in;
  logic [1:0]    fwd_rs, fwd_rt, md_read;
  logic [3:0]    alu_op;
  logic          alu_src;
  logic [2:0]    md_op;
  logic          md_busy;
  logic [31:0]   pc_out, instr_out;
  logic [DW-1:0] result_out, store_out;
  logic [4:0]    wa_out;
  logic          valid_out;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] m_hi = '0;
  logic [DW-1:0] m_lo = '0;

  always #5 clk = ~clk;

  execute_stage_md #(.DW(DW), .MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .i_clk(clk), .i_reset(reset), .i_ex_valid(ex_valid), .i_pc_in(pc_in), .i_instr_in(instr_in),
    .i_a_in(a_in), .i_b_in(b_in), .i_imm_in(imm_in), .i_wa_in(wa_in), .i_fwd_rs(fwd_rs),
    .i_fwd_rt(fwd_rt), .i_fwd_mem(fwd_mem), .i_fwd_wb(fwd_wb), .i_alu_op(alu_op),
    .i_alu_src(alu_src), .i_md_op(md_op), .i_md_read(md_read), .o_md_busy(md_busy),
    .o_pc_out(pc_out), .o_instr_out(instr_out), .o_result_out(result_out),
    .o_store_out(store_out), .o_wa_out(wa_out), .o_valid_out(valid_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; pc_in = '0; instr_in = '0; a_in = '0; b_in = '0; imm_in = '0;
    wa_in = '0; fwd_rs = '0; fwd_rt = '0; fwd_mem = '0; fwd_wb = '0; alu_op = '0;
    alu_src = 1'b0; md_op = '0; md_read = '0;
  endtask

  function automatic logic [DW-1:0] fsel(input logic [1:0] s, input logic [DW-1:0] rf,
                                         input logic [DW-1:0] mem, input logic [DW-1:0] wb);
    if (s == 2'd1) return mem;
    if (s == 2'd2) return wb;
    return rf;
  endfunction

  function automatic logic [DW-1:0] alu_ref(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    int sh;
    int sb;
    sh = int'(a % 32);
    sb = b;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ~(a | b);
      4'd6: return (int'(a) < sb) ? 32'd1 : 32'd0;
      4'd7: return (a < b) ? 32'd1 : 32'd0;
      4'd8: return b << sh;
      4'd9: return b >> sh;
      4'd10: return sb >>> sh;
      4'd11: return b * 32'h0001_0000;
      default: return '0;
    endcase
  endfunction

  // HI/LO effect of a completed mult/div on the model
  task automatic model_md(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint       ps;
    logic [63:0]  pu;
    int           sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'd1: begin ps = longint'(sa) * longint'(sb); pu = ps; m_hi = pu[63:32]; m_lo = pu[31:0]; end
      3'd2: begin pu = {32'b0, a} * {32'b0, b}; m_hi = pu[63:32]; m_lo = pu[31:0]; end
      3'd3: if (b != 0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo = a; m_hi = 0; end
        else begin m_lo = sa / sb; m_hi = sa % sb; end
      end
      3'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      default: ;
    endcase
  endtask

  task automatic read_hl(input logic [1:0] sel, output logic [DW-1:0] v);
    idle(); ex_valid = 1'b1; md_read = sel;
    tick();
    v = result_out;
    idle();
  endtask

  // Issue one mult/div, scramble the operand inputs afterwards, count md_busy cycles
  task automatic run_md(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output int cyc);
    idle(); ex_valid = 1'b1; md_op = op; a_in = a; b_in = b;
    #1;
    cyc = 0;
    while (md_busy === 1'b1 && cyc < 100) begin
      cyc++;
      tick();
      idle();
      a_in = $urandom; b_in = $urandom; fwd_mem = $urandom; fwd_wb = $urandom;
      fwd_rs = 2'($urandom_range(0, 3)); fwd_rt = 2'($urandom_range(0, 3));
      #1;
    end
    idle();
    model_md(op, a, b);
  endtask

  task automatic check_hilo(input string name);
    logic [DW-1:0] v;
    read_hl(2'd1, v);
    total++;
    if (v !== m_hi) begin bad++; $display("FAIL %s hi got=%h exp=%h", name, v, m_hi); end
    read_hl(2'd2, v);
    total++;
    if (v !== m_lo) begin bad++; $display("FAIL %s lo got=%h exp=%h", name, v, m_lo); end
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    idle(); reset = 1'b1;
    tick(); tick();
    total++;
    if ({pc_out, instr_out, result_out, store_out, wa_out, valid_out, md_busy} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {pc_out, instr_out, result_out, store_out});
    end
    reset = 1'b0;
    // seed HI with something nonzero so the reset clear is observable
    idle(); ex_valid = 1'b1; md_op = 3'd5; a_in = 32'hDEAD_BEEF; tick();
    idle(); ex_valid = 1'b1; md_op = 3'd1; a_in = 32'h0001_0000; b_in = 32'h0003_0000;
    tick(); idle(); tick(); tick();
    reset = 1'b1;
    tick(); tick();
    total++;
    if ({result_out, valid_out, md_busy} !== '0) begin
      bad++; $display("FAIL reset_midop got=%h busy=%b exp=0", result_out, md_busy);
    end
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    for (int i = 0; i < 8; i++) tick();
    read_hl(2'd1, v);
    total++;
    if (v !== 32'h0) begin bad++; $display("FAIL reset_mfhi got=%h exp=0", v); end
  endtask

  task automatic drive_alu(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] imm,
                           input logic src, input logic [1:0] frs, input logic [DW-1:0] mem,
                           input logic [DW-1:0] wb);
    idle(); ex_valid = 1'b1; alu_op = op; a_in = a; imm_in = imm; alu_src = src;
    b_in = imm; fwd_rs = frs; fwd_mem = mem; fwd_wb = wb;
    tick();
    idle();
  endtask

  task automatic test_alu_directed();
    drive_alu(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, 2'd0, '0, '0);
    total++;
    if (result_out !== 32'h8000_0000) begin bad++; $display("FAIL add_wrap got=%h exp=80000000", result_out); end
    drive_alu(4'd6, 32'hFFFF_FFFF, 32'd1, 1'b0, 2'd0, '0, '0);
    total++;
    if (result_out !== 32'd1) begin bad++; $display("FAIL slt got=%h exp=1", result_out); end
    drive_alu(4'd7, 32'hFFFF_FFFF, 32'd1, 1'b0, 2'd0, '0, '0);
    total++;
    if (result_out !== 32'd0) begin bad++; $display("FAIL sltu got=%h exp=0", result_out); end
    drive_alu(4'd0, 32'h99, 32'd4, 1'b1, 2'd1, 32'h10, 32'h0);
    total++;
    if (result_out !== 32'h14) begin bad++; $display("FAIL fwd_mem got=%h exp=14", result_out); end
    drive_alu(4'd0, 32'h99, 32'd4, 1'b1, 2'd2, 32'h10, 32'h20);
    total++;
    if (result_out !== 32'h24) begin bad++; $display("FAIL fwd_wb got=%h exp=24", result_out); end
  endtask

  task automatic test_alu_random();
    logic [DW-1:0] ea, ert, eb, exp_res;
    logic [31:0]   pc, ins;
    logic [4:0]    wa;
    for (int i = 0; i < 40; i++) begin
      idle();
      ex_valid = 1'b1;
      a_in = $urandom; b_in = $urandom; imm_in = $urandom; fwd_mem = $urandom; fwd_wb = $urandom;
      fwd_rs = 2'($urandom_range(0, 3)); fwd_rt = 2'($urandom_range(0, 3));
      alu_op = 4'($urandom_range(0, 15)); alu_src = 1'($urandom_range(0, 1));
      pc = $urandom; ins = $urandom; wa = 5'($urandom_range(0, 31));
      pc_in = pc; instr_in = ins; wa_in = wa;
      ea = fsel(fwd_rs, a_in, fwd_mem, fwd_wb);
      ert = fsel(fwd_rt, b_in, fwd_mem, fwd_wb);
      eb = alu_src ? imm_in : ert;
      exp_res = alu_ref(alu_op, ea, eb);
      tick();
      idle();
      total++;
      if (result_out !== exp_res) begin bad++; $display("FAIL alu_rand[%0d] got=%h exp=%h", i, result_out, exp_res); end
      total++;
      if ({pc_out, instr_out, store_out, wa_out, valid_out} !== {pc, ins, ert, wa, 1'b1}) begin
        bad++; $display("FAIL pipe_rand[%0d] got=%h/%h/%h/%h exp=%h/%h/%h/%h", i,
                        pc_out, instr_out, store_out, wa_out, pc, ins, ert, wa);
      end
    end
  endtask

  task automatic test_mult();
    int c;
    run_md(3'd1, 32'hFFFF_FFFE, 32'd3, c);
    total++;
    if (c != MC + 1) begin bad++; $display("FAIL mult_busy got=%0d exp=%0d", c, MC + 1); end
    check_hilo("mult");
    run_md(3'd2, 32'hFFFF_FFFE, 32'd3, c);
    check_hilo("multu");
    for (int i = 0; i < 6; i++) begin
      run_md(3'($urandom_range(1, 2)), $urandom, $urandom, c);
      total++;
      if (c != MC + 1) begin bad++; $display("FAIL mult_rand_busy got=%0d exp=%0d", c, MC + 1); end
      check_hilo("mult_rand");
    end
  endtask

  task automatic test_div();
    int c;
    logic [DW-1:0] d;
    run_md(3'd3, 32'hFFFF_FFF9, 32'd2, c);
    total++;
    if (c != DC + 1) begin bad++; $display("FAIL div_busy got=%0d exp=%0d", c, DC + 1); end
    check_hilo("div");
    run_md(3'd3, 32'h1234, 32'd0, c);
    total++;
    if (c != DC + 1) begin bad++; $display("FAIL div0_busy got=%0d exp=%0d", c, DC + 1); end
    check_hilo("div0");
    run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, c);
    check_hilo("div_ovf");
    for (int i = 0; i < 6; i++) begin
      d = (i == 5) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      if ($urandom_range(0, 1) == 1) d = -d;
      run_md(3'($urandom_range(3, 4)), $urandom, d, c);
      check_hilo("div_rand");
    end
  endtask

  task automatic test_mt_bubble();
    logic [DW-1:0] v;
    int c;
    idle(); ex_valid = 1'b1; md_op = 3'd6; a_in = 32'h1234; tick();
    m_lo = 32'h1234;
    read_hl(2'd2, v);
    total++;
    if (v !== 32'h1234) begin bad++; $display("FAIL mtlo got=%h exp=1234", v); end
    idle(); ex_valid = 1'b1; md_op = 3'd5; fwd_rs = 2'd1; fwd_mem = 32'hCAFE; a_in = 32'h1; tick();
    m_hi = 32'hCAFE;
    check_hilo("mthi");
    // mult followed by bubbles and an ignored mthi while busy
    idle(); ex_valid = 1'b1; md_op = 3'd1; a_in = 32'd7; b_in = 32'hFFFF_FFFB;
    tick();
    idle(); ex_valid = 1'b0; md_op = 3'd5; a_in = 32'h5555; pc_in = 32'h40;
    tick();
    total++;
    if ({valid_out, pc_out, result_out} !== '0) begin
      bad++; $display("FAIL bubble got valid=%b pc=%h exp=0", valid_out, pc_out);
    end
    idle(); ex_valid = 1'b1; md_op = 3'd5; a_in = 32'h7777;
    tick();
    idle();
    c = 0;
    while (md_busy === 1'b1 && c < 100) begin c++; tick(); end
    total++;
    if (c != MC - 2) begin bad++; $display("FAIL bubble_busy got=%0d exp=%0d", c, MC - 2); end
    model_md(3'd1, 32'd7, 32'hFFFF_FFFB);
    check_hilo("bubble_mult");
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_mult();
    test_div();
    test_mt_bubble();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
